fpu_wb_scheduler: RTL and testbench

Issue/writeback scheduler for the multi-latency ALU/FPU datapath. It replaces stall-per-op sequencing with pipelined issue. Independent FP ops issue back-to-back. A slot-reservation shift register guarantees at most one result per cycle on the single writeback port. A per-register busy scoreboard blocks RAW/WAW hazards against in-flight results. It sits between decode and the ALU and drives issue_ready (stall) and the writeback select/destination.

---
 rtl/fpu_sched_pkg.sv | 35 +++
 rtl/fpu_scoreboard.sv | 44 ++++
 rtl/fpu_wb_scheduler.sv | 93 +++++++++
 tb/tb_fpu_wb_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types, functop codes and latency classes for the FPU writeback scheduler
package fpu_sched_pkg;

    localparam int MAX_LAT = 3;
    localparam int NREG    = 64;

    localparam logic [5:0] FADD  = 6'b010000;
    localparam logic [5:0] FSUB  = 6'b010001;
    localparam logic [5:0] FMUL  = 6'b010010;
    localparam logic [5:0] FDIV  = 6'b010011;
    localparam logic [5:0] FSQRT = 6'b010100;
    localparam logic [5:0] FMIN  = 6'b010110;
    localparam logic [5:0] FMAX  = 6'b010111;
    localparam logic [5:0] FLT   = 6'b011001;
    localparam logic [5:0] FLE   = 6'b011010;
    localparam logic [5:0] ITOF  = 6'b011110;
    localparam logic [5:0] FTOI  = 6'b011111;

    typedef struct packed {
        logic       v;
        logic [5:0] rd;
        logic       we;
        logic [5:0] op;
    } slot_t;

    function automatic logic [1:0] lat_of(input logic [5:0] op);
        case (op)
            FDIV:                               lat_of = 2'd3;
            FADD, FSUB, FMUL, FSQRT:            lat_of = 2'd2;
            FMIN, FMAX, FLT, FLE, ITOF, FTOI:   lat_of = 2'd1;
            default:                            lat_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - per-register busy bits with set/clear and rs1/rs2/rd hazard lookup
module fpu_scoreboard
    import fpu_sched_pkg::*;
#(
    parameter int NREG_P = NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [5:0]        set_rd,
    input  logic              clr_en,
    input  logic [5:0]        clr_rd,
    input  logic [5:0]        rs1,
    input  logic [5:0]        rs2,
    input  logic [5:0]        rd,
    input  logic              chk_rd,
    output logic              haz,
    output logic [NREG_P-1:0] busy_vec
);

    logic [NREG_P-1:0] busy_q;
    logic [NREG_P-1:0] busy_d;

    // Set is applied after clear so a same-cycle set on a retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Lookup uses the registered vector: a dependent op waits one cycle past retirement.
    always_comb begin
        haz = busy_q[rs1] | busy_q[rs2] | (chk_rd & busy_q[rd]);
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/fpu_wb_scheduler.sv
// rtl/fpu_wb_scheduler.sv - pipelined issue with slot-reservation ring and single writeback port
module fpu_wb_scheduler
    import fpu_sched_pkg::slot_t;
    import fpu_sched_pkg::lat_of;
#(
    parameter int MAX_LAT = fpu_sched_pkg::MAX_LAT,
    parameter int NREG    = fpu_sched_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [5:0]      issue_op,
    input  logic [5:0]      issue_rd,
    input  logic            issue_we,
    input  logic [5:0]      issue_rs1,
    input  logic [5:0]      issue_rs2,
    output logic            issue_ready,
    output logic            wb_valid,
    output logic [5:0]      wb_rd,
    output logic [5:0]      wb_op,
    output logic [NREG-1:0] busy_vec
);

    slot_t [MAX_LAT-1:0] sr_q;
    slot_t [MAX_LAT-1:0] sr_d;

    logic [1:0] lat;
    logic       conflict;
    logic       haz;
    logic       fire;
    logic       sb_set;
    logic       sb_clr;

    assign lat = lat_of(issue_op);

    // Latency L lands in sr[L-1] next cycle, i.e. collides with whatever now sits in sr[L].
    always_comb begin
        conflict = 1'b0;
        if (lat == 2'd0) conflict = sr_q[0].v;
        for (int i = 1; i < MAX_LAT; i++) begin
            if (int'(lat) == i) conflict = sr_q[i].v;
        end
    end

    assign issue_ready = ~conflict & ~haz;
    assign fire        = issue_valid & issue_ready;

    always_comb begin
        for (int i = 0; i < MAX_LAT - 1; i++) sr_d[i] = sr_q[i + 1];
        sr_d[MAX_LAT-1] = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (fire && int'(lat) == i + 1) begin
                sr_d[i] = '{v: 1'b1, rd: issue_rd, we: issue_we, op: issue_op};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    always_comb begin
        if (fire && lat == 2'd0) begin
            wb_valid = 1'b1;
            wb_rd    = issue_rd;
            wb_op    = issue_op;
        end else begin
            wb_valid = sr_q[0].v & sr_q[0].we;
            wb_rd    = sr_q[0].rd;
            wb_op    = sr_q[0].op;
        end
    end

    assign sb_set = fire & (lat != 2'd0) & issue_we & (issue_rd != 6'd0);
    assign sb_clr = sr_q[0].v & sr_q[0].we;

    fpu_scoreboard #(.NREG_P(NREG)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_rd   (issue_rd),
        .clr_en   (sb_clr),
        .clr_rd   (sr_q[0].rd),
        .rs1      (issue_rs1),
        .rs2      (issue_rs2),
        .rd       (issue_rd),
        .chk_rd   (issue_we),
        .haz      (haz),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// tb/tb_fpu_wb_scheduler.sv - table-driven directed bench for fpu_wb_scheduler
module tb_fpu_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  issue_op;
    logic [5:0]  issue_rd;
    logic        issue_we;
    logic [5:0]  issue_rs1;
    logic [5:0]  issue_rs2;
    logic        issue_ready;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [5:0]  wb_op;
    logic [63:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] OP_FDIV = 6'h13;
    localparam logic [5:0] OP_FADD = 6'h10;
    localparam logic [5:0] OP_FMUL = 6'h12;
    localparam logic [5:0] OP_FLT  = 6'h19;
    localparam logic [5:0] OP_FNEG = 6'h15;
    localparam logic [5:0] OP_IADD = 6'h00;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [5:0]  rd;
        logic        we;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        rdy;
        logic        wbv;
        logic [5:0]  wrd;
        logic [5:0]  wop;
        logic [63:0] busy;
    } vec_t;

    vec_t tbl[29];

    fpu_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_we    (issue_we),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_op       (wb_op),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] b(input int n);
        b = 64'd1 << n;
    endfunction

    function automatic vec_t op_row(input logic [5:0] op, input logic [5:0] rd, input logic [5:0] rs1,
                                    input logic [5:0] rs2, input logic rdy, input logic wbv,
                                    input logic [5:0] wrd, input logic [5:0] wop, input logic [63:0] busy);
        op_row = '{1'b1, op, rd, 1'b1, rs1, rs2, rdy, wbv, wrd, wop, busy};
    endfunction

    function automatic vec_t idle_row(input logic rdy, input logic wbv, input logic [5:0] wrd,
                                      input logic [5:0] wop, input logic [63:0] busy);
        idle_row = '{1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, rdy, wbv, wrd, wop, busy};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] rd, input logic we,
                         input logic [5:0] rs1, input logic [5:0] rs2);
        issue_valid = v;
        issue_op    = op;
        issue_rd    = rd;
        issue_we    = we;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
    endtask

    initial begin
        // Back-to-back: fdiv f1, fadd f2 (slot collision), fneg f3 (lat0 vs retire)
        tbl[0]  = op_row(OP_FDIV, 6'd33, 6'd0, 6'd0, 1, 0, 0, 0, 64'd0);
        tbl[1]  = op_row(OP_FADD, 6'd34, 6'd0, 6'd0, 0, 0, 0, 0, b(33));
        tbl[2]  = op_row(OP_FADD, 6'd34, 6'd0, 6'd0, 1, 0, 0, 0, b(33));
        tbl[3]  = op_row(OP_FNEG, 6'd35, 6'd0, 6'd0, 0, 1, 6'd33, OP_FDIV, b(33) | b(34));
        tbl[4]  = op_row(OP_FNEG, 6'd35, 6'd0, 6'd0, 0, 1, 6'd34, OP_FADD, b(34));
        tbl[5]  = op_row(OP_FNEG, 6'd35, 6'd0, 6'd0, 1, 1, 6'd35, OP_FNEG, 64'd0);
        // RAW: fmul f4 then fadd f5 = f4 + f6
        tbl[6]  = op_row(OP_FMUL, 6'd36, 6'd0, 6'd0, 1, 0, 0, 0, 64'd0);
        tbl[7]  = op_row(OP_FADD, 6'd37, 6'd36, 6'd38, 0, 0, 0, 0, b(36));
        tbl[8]  = op_row(OP_FADD, 6'd37, 6'd36, 6'd38, 0, 1, 6'd36, OP_FMUL, b(36));
        tbl[9]  = op_row(OP_FADD, 6'd37, 6'd36, 6'd38, 1, 0, 0, 0, 64'd0);
        tbl[10] = idle_row(1, 0, 0, 0, b(37));
        tbl[11] = idle_row(0, 1, 6'd37, OP_FADD, b(37));
        // x0 never busy; f0 tracked
        tbl[12] = op_row(OP_FDIV, 6'd0, 6'd0, 6'd0, 1, 0, 0, 0, 64'd0);
        tbl[13] = idle_row(1, 0, 0, 0, 64'd0);
        tbl[14] = idle_row(1, 0, 0, 0, 64'd0);
        tbl[15] = op_row(OP_FDIV, 6'd32, 6'd0, 6'd0, 1, 1, 6'd0, OP_FDIV, 64'd0);
        tbl[16] = idle_row(1, 0, 0, 0, b(32));
        tbl[17] = idle_row(1, 0, 0, 0, b(32));
        tbl[18] = idle_row(0, 1, 6'd32, OP_FDIV, b(32));
        // flt f7 then integer add x5 collides with the retiring slot
        tbl[19] = op_row(OP_FLT, 6'd39, 6'd0, 6'd0, 1, 0, 0, 0, 64'd0);
        tbl[20] = op_row(OP_IADD, 6'd5, 6'd0, 6'd0, 0, 1, 6'd39, OP_FLT, b(39));
        tbl[21] = op_row(OP_IADD, 6'd5, 6'd0, 6'd0, 1, 1, 6'd5, OP_IADD, 64'd0);
        // Ring full: three fdivs back to back
        tbl[22] = op_row(OP_FDIV, 6'd33, 6'd0, 6'd0, 1, 0, 0, 0, 64'd0);
        tbl[23] = op_row(OP_FDIV, 6'd34, 6'd0, 6'd0, 1, 0, 0, 0, b(33));
        tbl[24] = op_row(OP_FDIV, 6'd35, 6'd0, 6'd0, 1, 0, 0, 0, b(33) | b(34));
        tbl[25] = idle_row(0, 1, 6'd33, OP_FDIV, b(33) | b(34) | b(35));
        tbl[26] = idle_row(0, 1, 6'd34, OP_FDIV, b(34) | b(35));
        tbl[27] = idle_row(0, 1, 6'd35, OP_FDIV, b(35));
        tbl[28] = idle_row(1, 0, 0, 0, 64'd0);

        rst = 1'b1;
        drive(0, 6'd0, 6'd0, 0, 6'd0, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        chk("reset wb_rd", 64'(wb_rd), 64'd0);
        chk("reset wb_op", 64'(wb_op), 64'd0);
        chk("reset busy_vec", busy_vec, 64'd0);
        chk("reset issue_ready", 64'(issue_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].we, tbl[i].rs1, tbl[i].rs2);
            @(negedge clk);
            chk($sformatf("row%0d issue_ready", i), 64'(issue_ready), 64'(tbl[i].rdy));
            chk($sformatf("row%0d wb_valid", i), 64'(wb_valid), 64'(tbl[i].wbv));
            if (tbl[i].wbv) begin
                chk($sformatf("row%0d wb_rd", i), 64'(wb_rd), 64'(tbl[i].wrd));
                chk($sformatf("row%0d wb_op", i), 64'(wb_op), 64'(tbl[i].wop));
            end
            chk($sformatf("row%0d busy_vec", i), busy_vec, tbl[i].busy);
            @(posedge clk);
            #1;
        end

        // Reset mid-flight discards the pending fdiv
        drive(1, OP_FDIV, 6'd33, 1, 6'd0, 6'd0);
        @(negedge clk);
        chk("midrst fire ready", 64'(issue_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(0, 6'd0, 6'd0, 0, 6'd0, 6'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy before reset edge", busy_vec, b(33));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst busy_vec t2", busy_vec, 64'd0);
        chk("midrst ready t2", 64'(issue_ready), 64'd1);
        chk("midrst wb_valid t2", 64'(wb_valid), 64'd0);
        for (int t = 3; t < 5; t++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("midrst wb_valid t%0d", t), 64'(wb_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
